// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the sequential slice-serial adder/subtractor:
// operation encodings and the control FSM state type.
package addsub_seq_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit ripple-carry adder; also reports the carry into its top bit so
// the caller can derive signed overflow on the final slice.
module addsub_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic c_v;

    always_comb begin
        c_v    = cin_i;
        s_o    = '0;
        cmsb_o = 1'b0;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) begin
                cmsb_o = c_v;
            end
            s_o[i] = a_i[i] ^ b_i[i] ^ c_v;
            c_v    = (a_i[i] & b_i[i]) | (c_v & (a_i[i] ^ b_i[i]));
        end
        cout_o = c_v;
    end

endmodule

// File: rtl/addsub_seq.sv
// Sequential add/subtract: operands are latched on accept and summed SLICE
// bits per clock through one shared slice adder; flags are registered at the end.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             sign,
    output state_t           state_dbg
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || SLICE <= 0) begin : g_bad_slice
        $error("addsub_seq: WIDTH must be a positive multiple of SLICE");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. in_ready is high only in IDLE, out_valid only in DONE; a held
    // result and its flags do not change until out_ready is seen.

    state_t           state_q;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             cy_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, overflow_q, zero_q, sign_q;

    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_cout, sl_cmsb;

    assign sl_a = a_q[k_q * SLICE +: SLICE];
    assign sl_b = b_q[k_q * SLICE +: SLICE];

    addsub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (cy_q),
        .s_o    (sl_s),
        .cout_o (sl_cout),
        .cmsb_o (sl_cmsb)
    );

    always_comb begin
        sum_d = sum_q;
        sum_d[k_q * SLICE +: SLICE] = sl_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cy_q        <= 1'b0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1: invert b and seed the carry.
                        a_q        <= a;
                        b_q        <= (op == OP_SUB) ? ~b : b;
                        cy_q       <= (op == OP_SUB);
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q <= sum_d;
                    cy_q  <= sl_cout;
                    k_q   <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        carry_q     <= sl_cout;
                        overflow_q  <= sl_cmsb ^ sl_cout;
                        zero_q      <= (sum_d == '0);
                        sign_q      <= sum_d[WIDTH-1];
                        k_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq (WIDTH=64, SLICE=16) with hand-computed
// expected sums and flags; flags are compared as {carry,overflow,zero,sign}.
module tb_addsub_seq;
    import addsub_seq_pkg::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry, overflow, zero, sign;
    state_t       state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    addsub_seq #(.WIDTH(64), .SLICE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand set, let it be accepted, then scramble the inputs.
    task automatic issue(input logic opv, input logic [W-1:0] av, input logic [W-1:0] bv);
        op = opv;
        a = av;
        b = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op = ~opv;
        a = 64'hDEAD_BEEF_0123_4567;
        b = 64'h5A5A_A5A5_FFFF_0000;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input int lat, input logic [W-1:0] exp_sum,
                            input logic [3:0] exp_flags);
        vec_cnt++;
        if (lat !== 4) begin
            err_cnt++;
            $display("FAIL %s latency: got %0d expected 4", name, lat);
        end
        vec_cnt++;
        if (sum !== exp_sum) begin
            err_cnt++;
            $display("FAIL %s sum: got %h expected %h", name, sum, exp_sum);
        end
        vec_cnt++;
        if ({carry, overflow, zero, sign} !== exp_flags) begin
            err_cnt++;
            $display("FAIL %s flags cozs: got %b expected %b", name,
                     {carry, overflow, zero, sign}, exp_flags);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset handshake: got %b expected 10", {in_ready, out_valid});
        end
        vec_cnt++;
        if ({sum, carry, overflow, zero, sign} !== {64'd0, 4'b0000}) begin
            err_cnt++;
            $display("FAIL reset outputs: got %h_%b expected 0", sum, {carry, overflow, zero, sign});
        end
        vec_cnt++;
        if (state_dbg !== IDLE) begin
            err_cnt++;
            $display("FAIL reset state: got %0d expected %0d", state_dbg, IDLE);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat;
        issue(OP_ADD, 64'd5, 64'd7);
        wait_done(lat);
        check_op("add_5_7", lat, 64'd12, 4'b0000);
        handshake();
        issue(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done(lat);
        check_op("add_ovf", lat, 64'h8000_0000_0000_0000, 4'b0101);
        handshake();
        issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_done(lat);
        check_op("add_ripple", lat, 64'd0, 4'b1010);
        handshake();
    endtask

    task automatic test_sub();
        int lat;
        issue(OP_SUB, 64'd3, 64'd3);
        wait_done(lat);
        check_op("sub_3_3", lat, 64'd0, 4'b1010);
        handshake();
        issue(OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
        wait_done(lat);
        check_op("sub_min_1", lat, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(OP_ADD, 64'd10, 64'd20);
        wait_done(lat);
        check_op("hold_op", lat, 64'd30, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                in_valid = 1'b1;
                a = 64'd1000;
                b = 64'd1;
            end
            step();
            in_valid = 1'b0;
            vec_cnt++;
            if ({out_valid, in_ready, sum, carry, overflow, zero, sign} !== {2'b10, 64'd30, 4'b0000}) begin
                err_cnt++;
                $display("FAIL hold cycle %0d: got v%b r%b %h %b expected v1 r0 %h 0000", i,
                         out_valid, in_ready, sum, {carry, overflow, zero, sign}, 64'd30);
            end
        end
        handshake();
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL after handshake: got %b expected 10", {in_ready, out_valid});
        end
        issue(OP_SUB, 64'd50, 64'd8);
        wait_done(lat);
        check_op("b2b_sub", lat, 64'd42, 4'b1000);
        handshake();
    endtask

    task automatic test_reset_busy();
        int lat;
        issue(OP_ADD, 64'h1234, 64'h5678);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            err_cnt++;
            $display("FAIL async reset in busy: got %b expected 10", {in_ready, out_valid});
        end
        step();
        rst_n = 1'b1;
        step();
        issue(OP_ADD, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(lat);
        check_op("post_reset", lat, 64'd99, 4'b1000);
        handshake();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
